// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : shifter_pkg
// Purpose  : Shared op and state encodings for the iterative shift unit.
// Revision : 1.0
// ============================================================================
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'd0,
        OP_SRA = 2'd1,
        OP_SLL = 2'd2,
        OP_ROR = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Purpose  : Combinational single-step shifter; shifts a word by k per op.
//            Rotate support only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
// Revision : 1.0
// ============================================================================
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   k,
    input  shift_op_e        op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] sra_wide;
    logic [2*WIDTH-1:0] sra_shifted;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    logic [2*WIDTH-1:0] ror_shifted;
    assign ror_shifted = {data, data} >> k;
`endif

    // Arithmetic fill comes from the operand MSB captured at accept time.
    assign sra_wide    = {{WIDTH{fill}}, data};
    assign sra_shifted = sra_wide >> k;

    always_comb begin
        result = data >> k;
        case (op)
            OP_SRL: result = data >> k;
            OP_SRA: result = sra_shifted[WIDTH-1:0];
            OP_SLL: result = data << k;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            OP_ROR: result = ror_shifted[WIDTH-1:0];
`else
            OP_ROR: result = data >> k;
`endif
            default: result = data >> k;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module   : iterative_shifter
// Purpose  : Multi-cycle shifter, STEP_BITS positions per cycle, valid/ready.
//            Define ITERATIVE_SHIFTER_ROTATE_EN to make op 3 a rotate right.
// Revision : 1.0
// ============================================================================
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int SHW = $clog2(WIDTH);

    shift_state_e   state;
    shift_op_e      op;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0] count;
    logic           sign;
    logic [SHW-1:0] step;
    logic [WIDTH-1:0] stage_out;

    // Compare in SHW+1 bits so STEP_BITS == WIDTH is representable.
    always_comb begin
        step = SHW'(STEP_BITS);
        if ({1'b0, count} < (SHW+1)'(STEP_BITS)) begin
            step = count;
        end
    end

    shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .data   (data),
        .k      (step),
        .op     (op),
        .fill   (sign),
        .result (stage_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op    <= OP_SRL;
            data  <= '0;
            count <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in_data;
                        op    <= shift_op_e'(in_op);
                        sign  <= in_data[WIDTH-1];
                        count <= in_shamt;
                        state <= (in_shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data  <= stage_out;
                    count <= count - step;
                    if (count == step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign out_data  = data;

endmodule
`default_nettype wire

// File: tb/tb_iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_shifter
// Purpose  : Directed self-checking bench for iterative_shifter (32-bit, step 4).
// Revision : 1.0
// ============================================================================
module tb_iterative_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clock = ~clock;

    iterative_shifter #(
        .WIDTH     (32),
        .STEP_BITS (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for out_valid; lat counts edges from accept.
    task automatic request(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        @(negedge clock);
        chk("in_ready_before_req", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = o;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);

        request(32'h8000_0000, 5'd31, 2'd0);
        chk("srl31_data", 64'(out_data), 64'h0000_0001);
        chk("srl31_lat", 64'(lat), 64'd9);
        handshake();

        request(32'h8000_0000, 5'd4, 2'd1);
        chk("sra4_neg_data", 64'(out_data), 64'hF800_0000);
        chk("sra4_neg_lat", 64'(lat), 64'd2);
        handshake();

        request(32'h4000_0000, 5'd4, 2'd1);
        chk("sra4_pos_data", 64'(out_data), 64'h0400_0000);
        handshake();

        request(32'h8000_0001, 5'd7, 2'd1);
        chk("sra7_data", 64'(out_data), 64'hFF00_0000);
        chk("sra7_lat", 64'(lat), 64'd3);
        handshake();

        request(32'h0000_0001, 5'd0, 2'd2);
        chk("sll0_data", 64'(out_data), 64'h0000_0001);
        chk("sll0_lat", 64'(lat), 64'd1);
        handshake();

        request(32'h0000_0001, 5'd31, 2'd2);
        chk("sll31_data", 64'(out_data), 64'h8000_0000);
        chk("sll31_lat", 64'(lat), 64'd9);
        handshake();

        request(32'h0000_000F, 5'd4, 2'd3);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        chk("ror4_data", 64'(out_data), 64'hF000_0000);
`else
        chk("ror4_data", 64'(out_data), 64'h0000_0000);
`endif
        chk("ror4_lat", 64'(lat), 64'd2);
        handshake();

        // Consumer stalls for 5 cycles while a stray request is offered
        request(32'h0000_0003, 5'd5, 2'd2);
        chk("stall_first_valid", 64'(out_valid), 64'd1);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd1;
        in_op    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("stall_data", 64'(out_data), 64'h0000_0060);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        handshake();
        chk("idle_holds_data", 64'(out_data), 64'h0000_0060);

        // Reset during the third SHIFT cycle discards the result
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd20;
        in_op    = 2'd0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) lat++;
        end
        chk("midrst_no_pulse", 64'(lat), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
